// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter: one holding buffer in front of a shift register.
// Words stream back to back; the holding buffer refills the shifter on the last bit.
module piso_serializer #(
   parameter int WIDTH      = 6,
   parameter bit MSB_FIRST  = 1'b0,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ena_in,
   input  logic [WIDTH-1:0] in,
   output logic             ready,
   output logic             out,
   output logic             ena_out,
   output logic             sof,
   output logic             eof,
   output logic             busy,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             out_q, out_d;
   logic             ena_out_q, ena_out_d;
   logic             sof_q, sof_d;
   logic             eof_q, eof_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    bit_idx;
   logic             accept;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      ovf_d       = ovf_q;
      out_d       = IDLE_LEVEL;
      ena_out_d   = 1'b0;
      sof_d       = 1'b0;
      eof_d       = 1'b0;
      accept      = ena_in && ready_q;
      bit_idx     = MSB_FIRST ? (LAST - cnt_q) : cnt_q;

      case (state_q)
         IDLE: begin
            if (hold_full_q) begin
               sh_d        = hold_q;
               hold_full_d = 1'b0;
               cnt_d       = '0;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            out_d     = sh_q[bit_idx];
            ena_out_d = 1'b1;
            sof_d     = (cnt_q == '0);
            eof_d     = (cnt_q == LAST);
            if (cnt_q != LAST) begin
               cnt_d = cnt_q + CW'(1);
            end else if (hold_full_q) begin
               // Reload on the last bit so the next word follows with no gap.
               sh_d        = hold_q;
               hold_full_d = 1'b0;
               cnt_d       = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A fresh accept overrides any transfer that emptied the buffer this cycle.
      if (accept) begin
         hold_d      = in;
         hold_full_d = 1'b1;
      end else if (ena_in) begin
         ovf_d = 1'b1;
      end

      ready_d = ~hold_full_d;
      busy_d  = hold_full_d | (state_d == SHIFT);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         out_q       <= IDLE_LEVEL;
         ena_out_q   <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         out_q       <= out_d;
         ena_out_q   <= ena_out_d;
         sof_q       <= sof_d;
         eof_q       <= eof_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
      end
   end

   assign ready   = ready_q;
   assign out     = out_q;
   assign ena_out = ena_out_q;
   assign sof     = sof_q;
   assign eof     = eof_q;
   assign busy    = busy_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: four configurations driven in parallel, each checked
// every cycle against a queue-of-bits reference model plus directed stream checks.
module tb_piso_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clr;
   logic       ena_in;
   logic [7:0] din;
   logic       o[4], eo[4], sf[4], ef[4], rd[4], bz[4], ov[4];

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   piso_serializer #(.WIDTH(6), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u0 (
      .clk(clk), .clr(clr), .ena_in(ena_in), .in(din[5:0]), .ready(rd[0]), .out(o[0]),
      .ena_out(eo[0]), .sof(sf[0]), .eof(ef[0]), .busy(bz[0]), .ovf(ov[0]));
   piso_serializer #(.WIDTH(6), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u1 (
      .clk(clk), .clr(clr), .ena_in(ena_in), .in(din[5:0]), .ready(rd[1]), .out(o[1]),
      .ena_out(eo[1]), .sof(sf[1]), .eof(ef[1]), .busy(bz[1]), .ovf(ov[1]));
   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u2 (
      .clk(clk), .clr(clr), .ena_in(ena_in), .in(din), .ready(rd[2]), .out(o[2]),
      .ena_out(eo[2]), .sof(sf[2]), .eof(ef[2]), .busy(bz[2]), .ovf(ov[2]));
   piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u3 (
      .clk(clk), .clr(clr), .ena_in(ena_in), .in(din[4:0]), .ready(rd[3]), .out(o[3]),
      .ena_out(eo[3]), .sof(sf[3]), .eof(ef[3]), .busy(bz[3]), .ovf(ov[3]));

   int mw[4]   = '{6, 6, 8, 5};
   bit mmsb[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   bit midl[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: a word becomes a queue of {sof,eof,bit}; one entry leaves per edge.
   logic [7:0] m_hold[4];
   bit         m_full[4], m_ovf[4];
   bit         m_o[4], m_e[4], m_s[4], m_f[4];
   logic [2:0] m_q[4][$];

   always @(posedge clk) begin
      for (int d = 0; d < 4; d++) begin
         if (clr) begin
            m_q[d].delete();
            m_full[d] = 1'b0;
            m_ovf[d]  = 1'b0;
            m_o[d] = midl[d]; m_e[d] = 1'b0; m_s[d] = 1'b0; m_f[d] = 1'b0;
         end else begin
            bit old_full;
            logic [2:0] ent;
            old_full = m_full[d];
            if (m_q[d].size() > 0) begin
               ent = m_q[d].pop_front();
               m_o[d] = ent[0]; m_e[d] = 1'b1; m_s[d] = ent[2]; m_f[d] = ent[1];
            end else begin
               m_o[d] = midl[d]; m_e[d] = 1'b0; m_s[d] = 1'b0; m_f[d] = 1'b0;
            end
            if (m_q[d].size() == 0 && old_full) begin
               for (int k = 0; k < mw[d]; k++) begin
                  int idx;
                  idx = mmsb[d] ? (mw[d] - 1 - k) : k;
                  m_q[d].push_back({(k == 0), (k == mw[d] - 1), m_hold[d][idx]});
               end
               m_full[d] = 1'b0;
            end
            if (ena_in) begin
               if (!old_full) begin
                  m_hold[d] = din & 8'((1 << mw[d]) - 1);
                  m_full[d] = 1'b1;
               end else begin
                  m_ovf[d] = 1'b1;
               end
            end
         end
      end
   end

   logic [15:0] cap_v[4];
   int cap_n[4], sof_n[4], eof_n[4], first_c[4], last_c[4];
   int cyc = 0;

   // Per-cycle scoreboard and stream capture, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      for (int d = 0; d < 4; d++) begin
         if (chk_en) begin
            chk($sformatf("cyc_u%0d", d),
                16'({o[d], eo[d], sf[d], ef[d], rd[d], bz[d], ov[d]}),
                16'({m_o[d], m_e[d], m_s[d], m_f[d], !m_full[d],
                     (m_full[d] || m_q[d].size() > 0), m_ovf[d]}));
         end
         if (eo[d] === 1'b1) begin
            cap_v[d] = {cap_v[d][14:0], o[d]};
            if (cap_n[d] == 0) first_c[d] = cyc;
            last_c[d] = cyc;
            cap_n[d]++;
            if (sf[d] === 1'b1) sof_n[d]++;
            if (ef[d] === 1'b1) eof_n[d]++;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_cap();
      for (int d = 0; d < 4; d++) begin
         cap_v[d] = '0; cap_n[d] = 0; sof_n[d] = 0; eof_n[d] = 0;
         first_c[d] = 0; last_c[d] = 0;
      end
   endtask

   task automatic accept(input logic [7:0] w);
      ena_in = 1'b1;
      din    = w;
      tick();
      ena_in = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((bz[0] | bz[1] | bz[2] | bz[3]) !== 1'b0 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("idle_timeout", 16'd1, 16'd0);
   endtask

   task automatic wait_ready0();
      int n;
      n = 0;
      while (rd[0] !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      if (n >= 30) chk("ready_timeout", 16'd1, 16'd0);
   endtask

   task automatic run_word(input logic [7:0] w);
      wait_idle();
      clear_cap();
      accept(w);
      repeat (12) tick();
   endtask

   initial begin
      clr = 1'b1; ena_in = 1'b0; din = '0;
      clear_cap();
      tick();
      chk_en = 1'b1;
      clr = 1'b0;
      chk("rst_ready", 16'(rd[0]), 16'd1);
      chk("rst_ovf", 16'(ov[0]), 16'd0);
      chk("rst_idle_level", 16'(o[3]), 16'd1);

      // Single words, both bit orders and all widths.
      run_word(8'h32);
      chk("w6_lsb_bits", cap_v[0], 16'b010011);
      chk("w6_lsb_n", 16'(cap_n[0]), 16'd6);
      chk("w6_sof_eof", 16'({sof_n[0][3:0], eof_n[0][3:0]}), 16'h11);
      chk("w6_span", 16'(last_c[0] - first_c[0]), 16'd5);
      chk("w6_msb_bits", cap_v[1], 16'b110010);
      chk("w8_bits_32", cap_v[2], 16'b01001100);
      chk("w5_bits_12", cap_v[3], 16'b01001);
      chk("w6_busy_after", 16'(bz[0]), 16'd0);
      run_word(8'hA5);
      chk("w8_bits_a5", cap_v[2], 16'hA5);
      chk("w8_eof", 16'(eof_n[2]), 16'd1);
      chk("w6_bits_25", cap_v[0], 16'b101001);
      run_word(8'h13);
      chk("w5_bits_13", cap_v[3], 16'b11001);
      chk("w5_n", 16'(cap_n[3]), 16'd5);

      // Back-to-back stream.
      wait_idle();
      clear_cap();
      accept(8'h32);
      wait_ready0();
      accept(8'h0F);
      repeat (16) tick();
      chk("b2b_bits", cap_v[0], 16'b010011111100);
      chk("b2b_n", 16'(cap_n[0]), 16'd12);
      chk("b2b_span", 16'(last_c[0] - first_c[0]), 16'd11);
      chk("b2b_sof_eof", 16'({sof_n[0][3:0], eof_n[0][3:0]}), 16'h22);

      // Overrun: third word arrives while the buffer is full.
      wait_idle();
      clear_cap();
      accept(8'h11);
      wait_ready0();
      accept(8'h22);
      accept(8'h3C);
      repeat (16) tick();
      chk("ovr_bits", cap_v[0], 16'b100010010001);
      chk("ovr_n", 16'(cap_n[0]), 16'd12);
      chk("ovr_flag", 16'(ov[0]), 16'd1);
      run_word(8'h2B);
      chk("ovr_sticky", 16'(ov[0]), 16'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("ovr_cleared", 16'(ov[0]), 16'd0);

      // Reset mid-frame with a pending word.
      wait_idle();
      clear_cap();
      accept(8'h32);
      wait_ready0();
      accept(8'h0F);
      begin
         int n;
         n = 0;
         while (cap_n[0] < 3 && n < 30) begin
            tick();
            n++;
         end
         if (n >= 30) chk("mid_timeout", 16'd1, 16'd0);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("mid_rst_outs", 16'({eo[0], sf[0], ef[0], rd[0], bz[0], o[0]}), 16'b000100);
      repeat (12) tick();
      chk("mid_no_resume", 16'(cap_n[0]), 16'd3);
      run_word(8'h32);
      chk("mid_restart", cap_v[0], 16'b010011);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         clr    = ($urandom_range(0, 99) == 0);
         ena_in = ($urandom_range(0, 2) != 0);
         din    = 8'($urandom);
         tick();
      end
      clr = 1'b0; ena_in = 1'b0;
      repeat (20) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
